weight_addr_gen_bank: RTL and testbench

Address-generator bank for the weight path of the systolic-array LSTM accelerator, sitting beside the weight buffers in the weight top. It holds three independent one-shot sequencers on one clock:
- **tin**: temp-buffer write addresses while the M×M weight matrix streams in from main memory.
- **h**: temp-buffer read addresses that scatter the matrix, zero-padded, into P weight DPRs.
- **ex**: weight-DPR read addresses, with active-lane count, during execution.

---
 rtl/weight_addr_gen_bank.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_weight_addr_gen_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_addr_gen_bank.sv
`default_nettype none
// ============================================================================
// Module   : weight_addr_gen_bank
// Purpose  : Address-generator bank for the LSTM accelerator weight path.
//            Three independent one-shot sequencers share a clock:
//              tin - temp-buffer write addresses while the MxM weight matrix
//                    streams in (0 .. M*M-1)
//              h   - temp-buffer read addresses that scatter the matrix into
//                    P weight DPRs. Rows past M-1 are padding and read the
//                    permanently-zero slot ZERO_ADDR.
//              ex  - weight-DPR read addresses during execution, plus the
//                    number of lanes carrying real data
// Ports    : sys_clk, reset_n (async, active-low)
//            <g>_start / <g>_clr   trigger / synchronous return to idle
//            <g>_addr              generated address (AW = 2*FEATURE_BITS)
//            <g>_valid / <g>_done  address live / sequence complete (sticky)
//            ex_active_lanes       active DPR lanes for ex_addr
// Revision : 1.0 - initial release
// ============================================================================
module weight_addr_gen_bank #(
  parameter int FEATURE_BITS = 4,
  parameter int P            = 4,
  parameter int M            = 9,
  parameter int GAMMA        = 3
) (
  input  logic                          sys_clk,
  input  logic                          reset_n,
  input  logic                          tin_start,
  input  logic                          h_start,
  input  logic                          ex_start,
  input  logic                          tin_clr,
  input  logic                          h_clr,
  input  logic                          ex_clr,
  output logic [2*FEATURE_BITS-1:0]     tin_addr,
  output logic [2*FEATURE_BITS-1:0]     h_addr,
  output logic [2*FEATURE_BITS-1:0]     ex_addr,
  output logic                          tin_valid,
  output logic                          h_valid,
  output logic                          ex_valid,
  output logic                          tin_done,
  output logic                          h_done,
  output logic                          ex_done,
  output logic [FEATURE_BITS-1:0]       ex_active_lanes
);

  localparam int AW = 2 * FEATURE_BITS;

  // Sequence lengths (last index) and address/lane constants
  localparam logic [AW-1:0] c_TIN_LAST  = AW'(M * M - 1);
  localparam logic [AW-1:0] c_H_LAST    = AW'(P * GAMMA * M - 1);
  localparam logic [AW-1:0] c_EX_LAST   = AW'(M * GAMMA - 1);
  localparam logic [AW-1:0] c_M         = AW'(M);
  localparam logic [AW-1:0] c_M_LAST    = AW'(M - 1);
  localparam logic [AW-1:0] c_ZERO_ADDR = AW'(M * M);
  localparam logic [AW-1:0] c_LAST_GRP  = AW'(GAMMA - 1);
  localparam logic [FEATURE_BITS-1:0] c_P_LANES = FEATURE_BITS'(P);
  localparam logic [FEATURE_BITS-1:0] c_R_LANES = FEATURE_BITS'(M - (GAMMA - 1) * P);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // tin generator: address is the index itself
  // --------------------------------------------------------------------------
  state_t          r_tin_state, w_tin_state_nxt;
  logic [AW-1:0]   r_tin_idx,   w_tin_idx_nxt;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tin_state <= ST_IDLE;
      r_tin_idx   <= '0;
    end else begin
      r_tin_state <= w_tin_state_nxt;
      r_tin_idx   <= w_tin_idx_nxt;
    end
  end

  always_comb begin
    w_tin_state_nxt = r_tin_state;
    w_tin_idx_nxt   = r_tin_idx;
    case (r_tin_state)
      ST_IDLE: begin
        // clr dominates start
        if (tin_start && !tin_clr) begin
          w_tin_state_nxt = ST_RUN;
          w_tin_idx_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (tin_clr) begin
          w_tin_state_nxt = ST_IDLE;
          w_tin_idx_nxt   = '0;
        end else if (r_tin_idx == c_TIN_LAST) begin
          // index held so the last address stays on the bus in DONE
          w_tin_state_nxt = ST_DONE;
        end else begin
          w_tin_idx_nxt = r_tin_idx + 1'b1;
        end
      end
      ST_DONE: begin
        if (tin_clr) begin
          w_tin_state_nxt = ST_IDLE;
          w_tin_idx_nxt   = '0;
        end
      end
      default: begin
        w_tin_state_nxt = ST_IDLE;
        w_tin_idx_nxt   = '0;
      end
    endcase
  end

  assign tin_addr  = r_tin_idx;
  assign tin_valid = (r_tin_state == ST_RUN);
  assign tin_done  = (r_tin_state == ST_DONE);

  // --------------------------------------------------------------------------
  // h generator: row/column counters track idx/M and idx%M without a divider.
  // While the row is inside the matrix, r*M+c equals the linear index, so the
  // address is either the next index or the zero slot.
  // --------------------------------------------------------------------------
  state_t          r_h_state, w_h_state_nxt;
  logic [AW-1:0]   r_h_idx,   w_h_idx_nxt;
  logic [AW-1:0]   r_h_row,   w_h_row_nxt;
  logic [AW-1:0]   r_h_col,   w_h_col_nxt;
  logic [AW-1:0]   r_h_addr,  w_h_addr_nxt;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_state <= ST_IDLE;
      r_h_idx   <= '0;
      r_h_row   <= '0;
      r_h_col   <= '0;
      r_h_addr  <= '0;
    end else begin
      r_h_state <= w_h_state_nxt;
      r_h_idx   <= w_h_idx_nxt;
      r_h_row   <= w_h_row_nxt;
      r_h_col   <= w_h_col_nxt;
      r_h_addr  <= w_h_addr_nxt;
    end
  end

  always_comb begin
    w_h_state_nxt = r_h_state;
    w_h_idx_nxt   = r_h_idx;
    w_h_row_nxt   = r_h_row;
    w_h_col_nxt   = r_h_col;
    w_h_addr_nxt  = r_h_addr;
    case (r_h_state)
      ST_IDLE: begin
        if (h_start && !h_clr) begin
          w_h_state_nxt = ST_RUN;
          w_h_idx_nxt   = '0;
          w_h_row_nxt   = '0;
          w_h_col_nxt   = '0;
          w_h_addr_nxt  = '0;
        end
      end
      ST_RUN: begin
        if (h_clr) begin
          w_h_state_nxt = ST_IDLE;
          w_h_idx_nxt   = '0;
          w_h_row_nxt   = '0;
          w_h_col_nxt   = '0;
          w_h_addr_nxt  = '0;
        end else if (r_h_idx == c_H_LAST) begin
          w_h_state_nxt = ST_DONE;
        end else begin
          w_h_idx_nxt = r_h_idx + 1'b1;
          if (r_h_col == c_M_LAST) begin
            w_h_col_nxt = '0;
            w_h_row_nxt = r_h_row + 1'b1;
          end else begin
            w_h_col_nxt = r_h_col + 1'b1;
          end
          w_h_addr_nxt = (w_h_row_nxt < c_M) ? w_h_idx_nxt : c_ZERO_ADDR;
        end
      end
      ST_DONE: begin
        if (h_clr) begin
          w_h_state_nxt = ST_IDLE;
          w_h_idx_nxt   = '0;
          w_h_row_nxt   = '0;
          w_h_col_nxt   = '0;
          w_h_addr_nxt  = '0;
        end
      end
      default: begin
        w_h_state_nxt = ST_IDLE;
        w_h_idx_nxt   = '0;
        w_h_row_nxt   = '0;
        w_h_col_nxt   = '0;
        w_h_addr_nxt  = '0;
      end
    endcase
  end

  assign h_addr  = r_h_addr;
  assign h_valid = (r_h_state == ST_RUN);
  assign h_done  = (r_h_state == ST_DONE);

  // --------------------------------------------------------------------------
  // ex generator: address is the index; a group counter (idx/M) selects the
  // lane count, where the final group may be only partially populated.
  // --------------------------------------------------------------------------
  state_t          r_ex_state, w_ex_state_nxt;
  logic [AW-1:0]   r_ex_idx,   w_ex_idx_nxt;
  logic [AW-1:0]   r_ex_grp,   w_ex_grp_nxt;
  logic [AW-1:0]   r_ex_col,   w_ex_col_nxt;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_state <= ST_IDLE;
      r_ex_idx   <= '0;
      r_ex_grp   <= '0;
      r_ex_col   <= '0;
    end else begin
      r_ex_state <= w_ex_state_nxt;
      r_ex_idx   <= w_ex_idx_nxt;
      r_ex_grp   <= w_ex_grp_nxt;
      r_ex_col   <= w_ex_col_nxt;
    end
  end

  always_comb begin
    w_ex_state_nxt = r_ex_state;
    w_ex_idx_nxt   = r_ex_idx;
    w_ex_grp_nxt   = r_ex_grp;
    w_ex_col_nxt   = r_ex_col;
    case (r_ex_state)
      ST_IDLE: begin
        if (ex_start && !ex_clr) begin
          w_ex_state_nxt = ST_RUN;
          w_ex_idx_nxt   = '0;
          w_ex_grp_nxt   = '0;
          w_ex_col_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (ex_clr) begin
          w_ex_state_nxt = ST_IDLE;
          w_ex_idx_nxt   = '0;
          w_ex_grp_nxt   = '0;
          w_ex_col_nxt   = '0;
        end else if (r_ex_idx == c_EX_LAST) begin
          w_ex_state_nxt = ST_DONE;
        end else begin
          w_ex_idx_nxt = r_ex_idx + 1'b1;
          if (r_ex_col == c_M_LAST) begin
            w_ex_col_nxt = '0;
            w_ex_grp_nxt = r_ex_grp + 1'b1;
          end else begin
            w_ex_col_nxt = r_ex_col + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (ex_clr) begin
          w_ex_state_nxt = ST_IDLE;
          w_ex_idx_nxt   = '0;
          w_ex_grp_nxt   = '0;
          w_ex_col_nxt   = '0;
        end
      end
      default: begin
        w_ex_state_nxt = ST_IDLE;
        w_ex_idx_nxt   = '0;
        w_ex_grp_nxt   = '0;
        w_ex_col_nxt   = '0;
      end
    endcase
  end

  assign ex_addr  = r_ex_idx;
  assign ex_valid = (r_ex_state == ST_RUN);
  assign ex_done  = (r_ex_state == ST_DONE);
  assign ex_active_lanes = (r_ex_state != ST_RUN)      ? '0 :
                           (r_ex_grp   == c_LAST_GRP)  ? c_R_LANES : c_P_LANES;

endmodule
`default_nettype wire

// File: tb/tb_weight_addr_gen_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_addr_gen_bank
// Purpose  : Directed self-checking bench for weight_addr_gen_bank at default
//            parameters (M=9, P=4, GAMMA=3, AW=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_addr_gen_bank;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tin_start = 1'b0, h_start = 1'b0, ex_start = 1'b0;
  logic       tin_clr = 1'b0, h_clr = 1'b0, ex_clr = 1'b0;
  logic [7:0] tin_addr, h_addr, ex_addr;
  logic       tin_valid, h_valid, ex_valid;
  logic       tin_done, h_done, ex_done;
  logic [3:0] ex_active_lanes;

  int vectors     = 0;
  int miscompares = 0;

  weight_addr_gen_bank dut (
    .sys_clk         (sys_clk),
    .reset_n         (reset_n),
    .tin_start       (tin_start),
    .h_start         (h_start),
    .ex_start        (ex_start),
    .tin_clr         (tin_clr),
    .h_clr           (h_clr),
    .ex_clr          (ex_clr),
    .tin_addr        (tin_addr),
    .h_addr          (h_addr),
    .ex_addr         (ex_addr),
    .tin_valid       (tin_valid),
    .h_valid         (h_valid),
    .ex_valid        (ex_valid),
    .tin_done        (tin_done),
    .h_done          (h_done),
    .ex_done         (ex_done),
    .ex_active_lanes (ex_active_lanes)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // one rising edge, then settle on the falling edge for sampling/driving
  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  initial begin
    // ---------------- reset state ----------------
    @(negedge sys_clk);
    tick();
    check("rst_tin_addr", tin_addr, 0);
    check("rst_h_addr", h_addr, 0);
    check("rst_ex_addr", ex_addr, 0);
    check("rst_valids", {tin_valid, h_valid, ex_valid}, 0);
    check("rst_dones", {tin_done, h_done, ex_done}, 0);
    check("rst_lanes", ex_active_lanes, 0);
    reset_n = 1'b1;
    tick();
    check("idle_tin_valid", tin_valid, 0);

    // ---------------- tin full sweep ----------------
    tin_start = 1'b1;
    tick();
    tin_start = 1'b0;
    for (int i = 0; i < 81; i++) begin
      check("tin_valid", tin_valid, 1);
      check("tin_addr", tin_addr, i);
      check("tin_done_early", tin_done, 0);
      tick();
    end
    for (int i = 0; i < 22; i++) begin
      check("tin_done_hold", tin_done, 1);
      check("tin_valid_after", tin_valid, 0);
      check("tin_addr_hold", tin_addr, 80);
      tin_start = i[0];
      tick();
    end
    tin_start = 1'b0;
    tin_clr = 1'b1;
    tick();
    tin_clr = 1'b0;
    check("tin_clr_done", tin_done, 0);
    check("tin_clr_addr", tin_addr, 0);

    // ---------------- h padding ----------------
    h_start = 1'b1;
    tick();
    h_start = 1'b0;
    for (int i = 0; i < 108; i++) begin
      check("h_valid", h_valid, 1);
      check("h_addr", h_addr, (i < 81) ? i : 81);
      check("h_done_early", h_done, 0);
      tick();
    end
    check("h_done", h_done, 1);
    check("h_valid_after", h_valid, 0);
    check("h_addr_hold", h_addr, 81);
    h_clr = 1'b1;
    tick();
    h_clr = 1'b0;
    check("h_clr_done", h_done, 0);

    // ---------------- ex lanes ----------------
    ex_start = 1'b1;
    tick();
    ex_start = 1'b0;
    for (int i = 0; i < 27; i++) begin
      check("ex_valid", ex_valid, 1);
      check("ex_addr", ex_addr, i);
      check("ex_lanes", ex_active_lanes, (i < 18) ? 4 : 1);
      tick();
    end
    check("ex_done", ex_done, 1);
    check("ex_valid_after", ex_valid, 0);
    check("ex_lanes_after", ex_active_lanes, 0);
    ex_clr = 1'b1;
    tick();
    ex_clr = 1'b0;

    // ---------------- clr behaviour ----------------
    ex_start = 1'b1;
    tick();
    ex_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("ex_pre_clr_addr", ex_addr, 10);
    ex_clr = 1'b1;
    tick();
    ex_clr = 1'b0;
    check("ex_clr_valid", ex_valid, 0);
    check("ex_clr_addr", ex_addr, 0);
    check("ex_clr_done", ex_done, 0);
    check("ex_clr_lanes", ex_active_lanes, 0);
    tick();
    check("ex_clr_stays_idle", ex_valid, 0);
    ex_start = 1'b1;
    tick();
    ex_start = 1'b0;
    for (int i = 0; i < 27; i++) begin
      check("ex_restart_addr", ex_addr, i);
      check("ex_restart_valid", ex_valid, 1);
      tick();
    end
    check("ex_restart_done", ex_done, 1);
    ex_clr = 1'b1;
    tick();
    ex_clr = 1'b0;
    ex_clr = 1'b1;
    ex_start = 1'b1;
    tick();
    ex_clr = 1'b0;
    ex_start = 1'b0;
    check("ex_clr_start_valid", ex_valid, 0);
    check("ex_clr_start_done", ex_done, 0);
    tick();
    check("ex_clr_start_idle", ex_valid, 0);

    // ---------------- async reset mid-run ----------------
    h_start = 1'b1;
    tick();
    h_start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    check("h_pre_rst_addr", h_addr, 40);
    #2 reset_n = 1'b0;
    #1;
    check("h_async_addr", h_addr, 0);
    check("h_async_valid", h_valid, 0);
    check("h_async_done", h_done, 0);
    #1 reset_n = 1'b1;
    @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      check("h_post_rst_valid", h_valid, 0);
      check("h_post_rst_done", h_done, 0);
      tick();
    end

    // ---------------- concurrency ----------------
    tin_start = 1'b1;
    h_start   = 1'b1;
    tick();
    tin_start = 1'b0;
    h_start   = 1'b0;
    for (int i = 0; i < 108; i++) begin
      check("cc_h_addr", h_addr, (i < 81) ? i : 81);
      check("cc_h_valid", h_valid, 1);
      if (i < 81) begin
        check("cc_tin_addr", tin_addr, i);
        check("cc_tin_valid", tin_valid, 1);
        check("cc_tin_done", tin_done, 0);
      end else begin
        check("cc_tin_done", tin_done, 1);
        check("cc_tin_valid", tin_valid, 0);
      end
      tick();
    end
    check("cc_h_done", h_done, 1);
    check("cc_h_valid_after", h_valid, 0);
    check("cc_tin_done_hold", tin_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
